// File: rtl/control_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module   : control_multiciclo
//  Purpose  : Multicycle processor control FSM for R-type, lw and sw.
//             Sequences FETCH / DECODE / EXEC / MEM / WB. An unsupported
//             opcode parks the FSM in ERR until reset.
//  Options  : INSTR_COUNT_EN - when defined, instr_count counts retired
//             instructions (one per done cycle, 16-bit wrap). Otherwise it
//             is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module control_multiciclo #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        instr_valid,
  input  logic [5:0]  op_code,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic        mem_to_reg,
  output logic [2:0]  alu_op_code,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [2:0] C_ALU_ADD   = 3'b000;
  localparam logic [2:0] C_ALU_RTYPE = 3'b010;

  state_t     r_state;
  state_t     w_next_state;
  logic [5:0] r_opcode;

  logic w_is_rtype;
  logic w_is_lw;
  logic w_is_sw;

  assign w_is_rtype = (r_opcode == OP_RTYPE);
  assign w_is_lw    = (r_opcode == OP_LW);
  assign w_is_sw    = (r_opcode == OP_SW);

  // State register and opcode latch; reset abandons any instruction at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_opcode <= 6'd0;
    end else begin
      r_state <= w_next_state;
      if (r_state == FETCH && instr_valid) begin
        r_opcode <= op_code;
      end
    end
  end

  // Next-state and strobe decode. done/illegal depend on state only, except
  // the sw completion in MEM which follows mem_ready in the same cycle.
  always_comb begin
    w_next_state     = r_state;
    pc_write         = 1'b0;
    ir_write         = 1'b0;
    reg_write        = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_to_reg       = 1'b0;
    alu_op_code      = C_ALU_ADD;
    busy             = 1'b0;
    done             = 1'b0;
    illegal          = 1'b0;
    case (r_state)
      IDLE: begin
        if (run) w_next_state = FETCH;
      end
      FETCH: begin
        if (instr_valid) begin
          pc_write     = 1'b1;
          ir_write     = 1'b1;
          w_next_state = DECODE;
        end
      end
      DECODE: begin
        busy = 1'b1;
        if (w_is_rtype || w_is_lw || w_is_sw) w_next_state = EXEC;
        else                                  w_next_state = ERR;
      end
      EXEC: begin
        busy         = 1'b1;
        alu_op_code  = w_is_rtype ? C_ALU_RTYPE : C_ALU_ADD;
        w_next_state = w_is_rtype ? WB : MEM;
      end
      MEM: begin
        busy             = 1'b1;
        mem_read_enable  = w_is_lw;
        mem_write_enable = w_is_sw;
        if (mem_ready) begin
          if (w_is_lw) begin
            w_next_state = WB;
          end else begin
            done         = 1'b1;
            w_next_state = run ? FETCH : IDLE;
          end
        end
      end
      WB: begin
        busy         = 1'b1;
        reg_write    = 1'b1;
        mem_to_reg   = w_is_lw;
        done         = 1'b1;
        w_next_state = run ? FETCH : IDLE;
      end
      ERR: begin
        illegal = 1'b1;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign state = r_state;

`ifdef INSTR_COUNT_EN
  logic [15:0] r_instr_count;

  // Retired-instruction counter; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_count <= 16'h0000;
    end else if (done) begin
      r_instr_count <= r_instr_count + 16'h0001;
    end
  end

  assign instr_count = r_instr_count;
`else
  assign instr_count = 16'h0000;
`endif

endmodule
`default_nettype wire
